// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm trigger block.
//   - FSM state encoding (2-bit, legacy-compatible localparams)
//   - Default ring / snooze / snooze-limit constants
//   - 48-bit alarm field layout {year, month, day, hour, minute, second}
package alarm_pkg;

  localparam int unsigned DefRingSec   = 60;
  localparam int unsigned DefSnoozeSec = 300;
  localparam int unsigned DefMaxSnooze = 3;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StRinging = 2'd2;
  localparam logic [1:0] StSnooze  = 2'd3;

  // Field order matches the packed bin_alarm word: year in [47:40], second in [7:0].
  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } alarm_time_t;

endpackage

// File: rtl/alarm_trigger_if.sv
// Bus bundle between the alarm trigger and its environment.
//   Inputs to the trigger: year..second (current time), bin_alarm (target),
//   arm (enable level), key_stop / key_snooze (1-cycle pulses).
//   Outputs from the trigger: buzzer, ringing, armed, snooze_cnt.
// modport master: environment side. modport slave: alarm_trigger side.
interface alarm_trigger_if;
  logic [7:0]  year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic [47:0] bin_alarm;
  logic        arm;
  logic        key_stop;
  logic        key_snooze;
  logic        buzzer;
  logic        ringing;
  logic        armed;
  logic [1:0]  snooze_cnt;

  modport master (
    output year, month, day, hour, minute, second, bin_alarm, arm, key_stop, key_snooze,
    input  buzzer, ringing, armed, snooze_cnt
  );

  modport slave (
    input  year, month, day, hour, minute, second, bin_alarm, arm, key_stop, key_snooze,
    output buzzer, ringing, armed, snooze_cnt
  );
endinterface

// File: rtl/tick_edge.sv
// Rising-edge detector for the 1 Hz clk1sec square wave, sampled in clk.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clk1sec : 1 Hz square wave, assumed synchronous to clk
//   tick    : high for exactly one clk cycle per clk1sec rising edge
module tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic clk1sec,
  output logic tick
);

  logic prev_q;

  // Reset to 1 so a clk1sec already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= clk1sec;
    end
  end

  assign tick = clk1sec & ~prev_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: arms on a non-zero alarm target, rings on the rising edge of
// time==alarm, supports a limited number of snoozes and auto-stops after
// RING_SEC seconds.
//   clk, rst : system clock, synchronous active-high reset
//   clk1sec  : 1 Hz square wave providing the seconds tick
//   bus      : alarm_trigger_if.slave (time, target, arm, keys in; buzzer,
//              ringing, armed, snooze_cnt out, all registered)
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = DefRingSec,
  parameter int unsigned SNOOZE_SEC = DefSnoozeSec,
  parameter int unsigned MAX_SNOOZE = DefMaxSnooze  // must fit the 2-bit snooze_cnt
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk1sec,
  alarm_trigger_if.slave  bus
);

  localparam int unsigned RW = (RING_SEC > 1) ? $clog2(RING_SEC + 1) : 1;
  localparam int unsigned WW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;

  localparam logic [RW-1:0] RingMax  = RW'(RING_SEC);
  localparam logic [WW-1:0] WaitInit = WW'(SNOOZE_SEC);
  localparam logic [1:0]    SnzMax   = 2'(MAX_SNOOZE);

  logic          tick;
  alarm_time_t   now;
  logic          match;
  logic          match_q;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ring_q, ring_d, ring_inc;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    snz_q, snz_d;
  logic          buzzer_q, ringing_q, armed_q;

  tick_edge u_tick_edge (
    .clk     (clk),
    .rst     (rst),
    .clk1sec (clk1sec),
    .tick    (tick)
  );

  assign now = '{year:   bus.year,
                 month:  bus.month,
                 day:    bus.day,
                 hour:   bus.hour,
                 minute: bus.minute,
                 second: bus.second};

  assign match    = (now == bus.bin_alarm) && (bus.bin_alarm != '0);
  assign ring_inc = ring_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    wait_d  = wait_q;
    snz_d   = snz_q;
    if (!bus.arm) begin
      state_d = StIdle;
      ring_d  = '0;
      wait_d  = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.bin_alarm != '0) state_d = StArmed;
        end
        StArmed: begin
          // Edge-triggered: a match already high on entry never fires.
          if (match && !match_q) begin
            state_d = StRinging;
            ring_d  = '0;
            snz_d   = '0;
          end
        end
        StRinging: begin
          if (bus.key_stop) begin
            state_d = StArmed;
            ring_d  = '0;
            snz_d   = '0;
          end else if (bus.key_snooze && (snz_q < SnzMax)) begin
            state_d = StSnooze;
            snz_d   = snz_q + 1'b1;
            wait_d  = WaitInit;
          end else if (tick) begin
            if (ring_inc >= RingMax) begin
              state_d = StArmed;
              ring_d  = '0;
              snz_d   = '0;
            end else begin
              ring_d = ring_inc;
            end
          end
        end
        StSnooze: begin
          if (bus.key_stop) begin
            state_d = StArmed;
            wait_d  = '0;
            snz_d   = '0;
          end else if (tick) begin
            if (wait_q <= WW'(1)) begin
              state_d = StRinging;
              ring_d  = '0;
              wait_d  = '0;
            end else begin
              wait_d = wait_q - 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ring_q    <= '0;
      wait_q    <= '0;
      snz_q     <= '0;
      match_q   <= 1'b1;  // blocks a trigger from a match already present at reset release
      buzzer_q  <= 1'b0;
      ringing_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      wait_q    <= wait_d;
      snz_q     <= snz_d;
      match_q   <= match;
      // Outputs decoded from next state so they line up with the state register.
      buzzer_q  <= (state_d == StRinging) && !ring_d[0];
      ringing_q <= (state_d == StRinging);
      armed_q   <= (state_d != StIdle);
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.ringing    = ringing_q;
  assign bus.armed      = armed_q;
  assign bus.snooze_cnt = snz_q;

endmodule

// File: tb/tb_alarm_trigger.sv
module tb_alarm_trigger;

  logic clk = 1'b0;
  logic rst;
  logic clk1sec;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_trigger_if bus ();

  alarm_trigger #(
    .RING_SEC   (4),
    .SNOOZE_SEC (2),
    .MAX_SNOOZE (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk1sec (clk1sec),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clk edge; outputs are stable 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    clk1sec = 1'b1;
    step();
    clk1sec = 1'b0;
    step();
  endtask

  task automatic pulse_snooze();
    bus.key_snooze = 1'b1;
    step();
    bus.key_snooze = 1'b0;
  endtask

  // Drop the match for one cycle and raise it again to fire a fresh event.
  task automatic retrigger();
    bus.second = 8'd6;
    step();
    bus.second = 8'd5;
    step();
  endtask

  task automatic check_outs(input string tag, input logic buz, input logic rng,
                            input logic arm_o, input logic [1:0] snz);
    check({tag, ".buzzer"}, 32'(bus.buzzer), 32'(buz));
    check({tag, ".ringing"}, 32'(bus.ringing), 32'(rng));
    check({tag, ".armed"}, 32'(bus.armed), 32'(arm_o));
    check({tag, ".snooze_cnt"}, 32'(bus.snooze_cnt), 32'(snz));
  endtask

  initial begin
    rst            = 1'b1;
    clk1sec        = 1'b0;
    bus.arm        = 1'b1;
    bus.key_stop   = 1'b0;
    bus.key_snooze = 1'b0;
    bus.year       = 8'd0;
    bus.month      = 8'd0;
    bus.day        = 8'd0;
    bus.hour       = 8'd0;
    bus.minute     = 8'd0;
    bus.second     = 8'd0;
    bus.bin_alarm  = '0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);

    // arm with an all-zero alarm target must stay idle
    rst = 1'b0;
    step();
    step();
    check("zero_alarm.armed", 32'(bus.armed), 32'd0);

    // 24-01-01 12:00:04, alarm at 12:00:05
    bus.year      = 8'd24;
    bus.month     = 8'd1;
    bus.day       = 8'd1;
    bus.hour      = 8'd12;
    bus.second    = 8'd4;
    bus.bin_alarm = {8'd24, 8'd1, 8'd1, 8'd12, 8'd0, 8'd5};
    step();
    check_outs("arm", 1'b0, 1'b0, 1'b1, 2'd0);

    bus.second = 8'd5;
    step();
    check_outs("match_ring", 1'b1, 1'b1, 1'b1, 2'd0);

    // auto-stop after four ticks, buzzer toggling each second
    do_tick();
    check("ring_t1.buzzer", 32'(bus.buzzer), 32'd0);
    check("ring_t1.ringing", 32'(bus.ringing), 32'd1);
    do_tick();
    check("ring_t2.buzzer", 32'(bus.buzzer), 32'd1);
    do_tick();
    check("ring_t3.buzzer", 32'(bus.buzzer), 32'd0);
    do_tick();
    check_outs("ring_t4_autostop", 1'b0, 1'b0, 1'b1, 2'd0);

    // match still held: no retrigger without a fresh edge
    step();
    step();
    check("held_match.ringing", 32'(bus.ringing), 32'd0);

    // three snoozes, each re-ringing after two ticks
    retrigger();
    check("retrigger.ringing", 32'(bus.ringing), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      pulse_snooze();
      check_outs($sformatf("snooze%0d", i), 1'b0, 1'b0, 1'b1, 2'(i));
      do_tick();
      check($sformatf("snooze%0d_t1.ringing", i), 32'(bus.ringing), 32'd0);
      do_tick();
      check_outs($sformatf("snooze%0d_rering", i), 1'b1, 1'b1, 1'b1, 2'(i));
    end
    pulse_snooze();
    check_outs("snooze4_ignored", 1'b1, 1'b1, 1'b1, 2'd3);

    bus.key_stop = 1'b1;
    step();
    bus.key_stop = 1'b0;
    check_outs("stop_ringing", 1'b0, 1'b0, 1'b1, 2'd0);

    // key_stop and tick in the same cycle while snoozing
    retrigger();
    pulse_snooze();
    check("snz_for_stop.snooze_cnt", 32'(bus.snooze_cnt), 32'd1);
    bus.key_stop = 1'b1;
    clk1sec      = 1'b1;
    step();
    bus.key_stop = 1'b0;
    clk1sec      = 1'b0;
    check_outs("stop_tick_snooze", 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    step();
    check("stop_tick_snooze_hold.ringing", 32'(bus.ringing), 32'd0);

    // arm dropped together with key_snooze while ringing with one snooze used
    retrigger();
    pulse_snooze();
    do_tick();
    do_tick();
    check("pre_disarm.snooze_cnt", 32'(bus.snooze_cnt), 32'd1);
    check("pre_disarm.ringing", 32'(bus.ringing), 32'd1);
    bus.arm        = 1'b0;
    bus.key_snooze = 1'b1;
    step();
    bus.key_snooze = 1'b0;
    check_outs("disarm", 1'b0, 1'b0, 1'b0, 2'd0);

    // re-arm with match held, ring, then reset mid-ring
    bus.arm = 1'b1;
    step();
    step();
    check("rearm_held.ringing", 32'(bus.ringing), 32'd0);
    retrigger();
    check("pre_rst.buzzer", 32'(bus.buzzer), 32'd1);
    rst = 1'b1;
    step();
    check_outs("rst_mid_ring", 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    step();
    check("post_rst.armed", 32'(bus.armed), 32'd1);
    step();
    step();
    check("post_rst_held.ringing", 32'(bus.ringing), 32'd0);
    retrigger();
    check_outs("post_rst_retrigger", 1'b1, 1'b1, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameter RING_SEC, default 60, SHALL set the ring duration in seconds before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300, SHALL set the snooze wait in seconds.
REQ-003 Parameter MAX_SNOOZE, default 3, SHALL set the snoozes allowed per alarm event.
REQ-004 clk  in  1  system clock; all logic on rising edge; single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 clk1sec  in  1  1 Hz square wave; each rising edge, detected in clk, SHALL form one internal 1-cycle tick.
REQ-007 year, month, day, hour, minute, second  in  8 each  current binary time.
REQ-008 bin_alarm  in  48  alarm target {year,month,day,hour,minute,second}; all-zero means "no alarm".
REQ-009 arm  in  1  level; 1 enables the alarm.
REQ-010 key_stop, key_snooze  in  1 each  single-cycle key pulses.
REQ-011 buzzer  out  1  beep drive.
REQ-012 ringing  out  1  high in RINGING.
REQ-013 armed  out  1  high in any state other than IDLE.
REQ-014 snooze_cnt  out  2  snoozes used in the current event.

Function
REQ-015 FSM states SHALL be IDLE, ARMED, RINGING, SNOOZE.
REQ-016 match SHALL equal ({year,month,day,hour,minute,second} == bin_alarm) && (bin_alarm != 0); match_d SHALL be match registered.
REQ-017 IDLE->ARMED SHALL occur when arm=1 and bin_alarm != 0.
REQ-018 ARMED->RINGING SHALL occur on the cycle where match=1 and match_d=0; ring_cnt SHALL clear and snooze_cnt SHALL clear on this transition.
REQ-019 A match that is continuously high while entering ARMED SHALL NOT trigger (rising edge only).
REQ-020 In RINGING, each tick SHALL increment ring_cnt; when ring_cnt reaches RING_SEC, the FSM SHALL go to ARMED with snooze_cnt cleared.
REQ-021 In RINGING, buzzer SHALL equal NOT ring_cnt[0] (1 s on, 1 s off, on at entry); in all other states, buzzer SHALL be 0.
REQ-022 In RINGING, key_snooze with snooze_cnt < MAX_SNOOZE SHALL go to SNOOZE, increment snooze_cnt, and load wait_cnt = SNOOZE_SEC.
REQ-023 key_snooze with snooze_cnt == MAX_SNOOZE SHALL be ignored.
REQ-024 In SNOOZE, each tick SHALL decrement wait_cnt; on reaching 0, the FSM SHALL go to RINGING with ring_cnt cleared.
REQ-025 key_stop in RINGING or SNOOZE SHALL go to ARMED with snooze_cnt cleared.
REQ-026 arm=0 in any state SHALL go to IDLE next cycle and clear all counters.
REQ-027 Same-cycle priority SHALL be: arm=0 > key_stop > key_snooze > tick/timeout.
REQ-028 Changes to bin_alarm while in RINGING or SNOOZE SHALL NOT affect the current event.
REQ-029 Counters SHALL be sized to hold their parameter value without wrap; ring_cnt and wait_cnt SHALL never wrap.
REQ-030 Outputs SHALL be registered; state change SHALL be visible 1 clk after the causing input.

Reset
REQ-031 rst=1 SHALL force state=IDLE, buzzer=0, ringing=0, armed=0, snooze_cnt=0, ring_cnt=0, wait_cnt=0, match_d=1, and the clk1sec edge register=1.
REQ-032 Reset mid-ring SHALL silence buzzer on the next clk edge; no trigger SHALL be produced by the first post-reset match.

Structure
REQ-033 The state encoding, default RING_SEC/SNOOZE_SEC/MAX_SNOOZE constants and the 48-bit alarm field layout SHALL live in shared package alarm_pkg.
REQ-034 The clk1sec rising-edge detector SHALL be sub-module tick_edge (in clk1sec, out tick 1-cycle).

Verification
REQ-035 arm=1, bin_alarm=12:00:05, time advances 12:00:04->05 -> ringing=1 one clk after match, buzzer=1.
REQ-036 Ringing, no keys, RING_SEC=4 -> buzzer 1,0,1,0 per tick, then state ARMED, ringing=0.
REQ-037 Ringing, key_snooze x3 each after SNOOZE_SEC=2 re-ring -> snooze_cnt=1,2,3; 4th key_snooze ignored, ringing stays 1.
REQ-038 SNOOZE with key_stop and tick same cycle -> ARMED, snooze_cnt=0, buzzer=0.
REQ-039 Ringing, arm dropped together with key_snooze -> IDLE, armed=0, snooze_cnt=0.
REQ-040 rst pulsed mid-ring while time==bin_alarm held -> buzzer=0 next clk; after arm, no retrigger until match falls and rises again.
